// File: rtl/gigatron_keyin_pkg.sv
// Shared types and constants for the Gigatron PS/2 keyboard front end:
// receiver/decoder states, scancodes, button bit positions and the ASCII table.
package gigatron_keyin_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TO_W   = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_NORM, DEC_BRK, DEC_EXT, DEC_EXTBRK} dec_state_t;

  localparam logic [BYTE_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK    = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_RIGHT  = 8'h74;
  localparam logic [BYTE_W-1:0] SC_LEFT   = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_DOWN   = 8'h72;
  localparam logic [BYTE_W-1:0] SC_UP     = 8'h75;
  localparam logic [BYTE_W-1:0] SC_START  = 8'h5A;
  localparam logic [BYTE_W-1:0] SC_SELECT = 8'h76;
  localparam logic [BYTE_W-1:0] SC_B      = 8'h11;
  localparam logic [BYTE_W-1:0] SC_A      = 8'h14;

  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_A      = 7;

  localparam logic [BYTE_W-1:0] ASCII_NONE = 8'hFF;

  // Set-2 scancode to lowercase ASCII; ASCII_NONE when the code has no mapping.
  function automatic logic [BYTE_W-1:0] sc_to_ascii(input logic [BYTE_W-1:0] sc);
    logic [BYTE_W-1:0] a;
    case (sc)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      default: a = ASCII_NONE;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, start/data/parity/stop FSM and an
// inactivity timeout that discards partial frames.
module ps2_rx
  import gigatron_keyin_pkg::*;
#(
  parameter int unsigned TIMEOUT = 6250
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              i_ps2_clk,
  input  logic              i_ps2_data,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_strobe,
  output logic              o_perr
);

  logic              r_clk_s1, r_clk_s2, r_clk_d, r_dat_s1, r_dat_s2;
  rx_state_t         r_state, w_state_nxt;
  logic [BYTE_W-1:0] r_shift, w_shift_nxt;
  logic [2:0]        r_bitcnt, w_bitcnt_nxt;
  logic              r_par, w_par_nxt;
  logic [TO_W-1:0]   r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0] r_byte, w_byte_nxt;
  logic              r_strobe, w_strobe_nxt;
  logic              r_perr, w_perr_nxt;
  logic              w_fall;

  assign w_fall = r_clk_d & ~r_clk_s2;

  // Next-state logic; the timeout override is applied last so it wins.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_par_nxt    = r_par;
    w_byte_nxt   = r_byte;
    w_strobe_nxt = 1'b0;
    w_perr_nxt   = 1'b0;
    if (w_fall || r_state == RX_IDLE) w_cnt_nxt = '0;
    else                              w_cnt_nxt = r_cnt + TO_W'(1);

    case (r_state)
      RX_IDLE: if (w_fall && !r_dat_s2) begin
        w_state_nxt  = RX_DATA;
        w_bitcnt_nxt = '0;
      end
      RX_DATA: if (w_fall) begin
        w_shift_nxt  = {r_dat_s2, r_shift[BYTE_W-1:1]};
        w_bitcnt_nxt = r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) w_state_nxt = RX_PARITY;
      end
      RX_PARITY: if (w_fall) begin
        w_par_nxt   = r_dat_s2;
        w_state_nxt = RX_STOP;
      end
      RX_STOP: if (w_fall) begin
        w_state_nxt = RX_IDLE;
        if (r_dat_s2 && (^{r_shift, r_par})) begin
          w_strobe_nxt = 1'b1;
          w_byte_nxt   = r_shift;
        end else begin
          w_perr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase

    if (r_state != RX_IDLE && r_cnt >= TO_W'(TIMEOUT)) begin
      w_state_nxt  = RX_IDLE;
      w_strobe_nxt = 1'b0;
      w_perr_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_state  <= RX_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_cnt    <= '0;
      r_byte   <= '0;
      r_strobe <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_par    <= w_par_nxt;
      r_cnt    <= w_cnt_nxt;
      r_byte   <= w_byte_nxt;
      r_strobe <= w_strobe_nxt;
      r_perr   <= w_perr_nxt;
    end
  end

  assign o_byte   = r_byte;
  assign o_strobe = r_strobe;
  assign o_perr   = r_perr;

endmodule

// File: rtl/gigatron_keyin.sv
// Gigatron input-byte producer: PS/2 scancode decoder into active-low buttons,
// latched to inreg on each vsync rising edge. Optional ASCII mode: GIGATRON_KEYIN_ASCII_EN.
module gigatron_keyin
  import gigatron_keyin_pkg::*;
#(
  parameter int unsigned TIMEOUT = 6250
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic [BYTE_W-1:0] vga,
  output logic [BYTE_W-1:0] inreg,
  output logic              perr
);

  logic [BYTE_W-1:0] w_byte;
  logic              w_strobe;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clock      (clock),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_byte     (w_byte),
    .o_strobe   (w_strobe),
    .o_perr     (perr)
  );

  dec_state_t        r_dec, w_dec_nxt;
  logic [BYTE_W-1:0] r_btn, w_btn_nxt;
  logic [BYTE_W-1:0] r_inreg, w_present;
  logic              r_vs_prev;
  logic              w_apply, w_ext, w_brk, w_hit;
  logic [2:0]        w_idx;
  logic              w_unused_vga;

  assign w_unused_vga = ^vga[BYTE_W-2:0];

  // Prefix tracking: E0/F0 set the context that the next plain byte is applied in.
  always_comb begin
    w_dec_nxt = r_dec;
    w_apply   = 1'b0;
    w_ext     = 1'b0;
    w_brk     = 1'b0;
    if (w_strobe) begin
      case (r_dec)
        DEC_NORM:
          if (w_byte == SC_EXT)      w_dec_nxt = DEC_EXT;
          else if (w_byte == SC_BRK) w_dec_nxt = DEC_BRK;
          else                       w_apply   = 1'b1;
        DEC_BRK: begin
          w_apply = 1'b1;
          w_brk   = 1'b1;
        end
        DEC_EXT:
          if (w_byte == SC_BRK) w_dec_nxt = DEC_EXTBRK;
          else begin
            w_apply = 1'b1;
            w_ext   = 1'b1;
          end
        DEC_EXTBRK: begin
          w_apply = 1'b1;
          w_ext   = 1'b1;
          w_brk   = 1'b1;
        end
        default: w_dec_nxt = DEC_NORM;
      endcase
      if (w_apply) w_dec_nxt = DEC_NORM;
    end
  end

  // Button map: make clears, break sets; unmapped codes fall through.
  always_comb begin
    w_btn_nxt = r_btn;
    w_hit     = 1'b1;
    w_idx     = '0;
    case ({w_ext, w_byte})
      {1'b1, SC_RIGHT}:  w_idx = 3'(BTN_RIGHT);
      {1'b1, SC_LEFT}:   w_idx = 3'(BTN_LEFT);
      {1'b1, SC_DOWN}:   w_idx = 3'(BTN_DOWN);
      {1'b1, SC_UP}:     w_idx = 3'(BTN_UP);
      {1'b0, SC_START}:  w_idx = 3'(BTN_START);
      {1'b0, SC_SELECT}: w_idx = 3'(BTN_SELECT);
      {1'b0, SC_B}:      w_idx = 3'(BTN_B);
      {1'b0, SC_A}:      w_idx = 3'(BTN_A);
      default:           w_hit = 1'b0;
    endcase
    if (w_apply && w_hit) w_btn_nxt[w_idx] = w_brk;
  end

`ifdef GIGATRON_KEYIN_ASCII_EN
  logic [BYTE_W-1:0] r_ascii, w_ascii_nxt;
  logic [BYTE_W-1:0] r_ascii_code, w_ascii_code_nxt;
  logic [BYTE_W-1:0] w_sc_ascii;

  assign w_sc_ascii = sc_to_ascii(w_byte);

  // Only the key that loaded the register may clear it on release.
  always_comb begin
    w_ascii_nxt      = r_ascii;
    w_ascii_code_nxt = r_ascii_code;
    if (w_apply && !w_ext) begin
      if (!w_brk && w_sc_ascii != ASCII_NONE) begin
        w_ascii_nxt      = w_sc_ascii;
        w_ascii_code_nxt = w_byte;
      end else if (w_brk && w_byte == r_ascii_code) begin
        w_ascii_nxt = ASCII_NONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_ascii      <= ASCII_NONE;
      r_ascii_code <= '0;
    end else begin
      r_ascii      <= w_ascii_nxt;
      r_ascii_code <= w_ascii_code_nxt;
    end
  end

  assign w_present = (r_ascii != ASCII_NONE) ? r_ascii : r_btn;
`else
  assign w_present = r_btn;
`endif

  // inreg samples the pre-update button state, so a coincident strobe waits a frame.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_dec     <= DEC_NORM;
      r_btn     <= 8'hFF;
      r_inreg   <= 8'hFF;
      r_vs_prev <= 1'b1;
    end else begin
      r_dec     <= w_dec_nxt;
      r_btn     <= w_btn_nxt;
      r_vs_prev <= vga[BYTE_W-1];
      if (vga[BYTE_W-1] && !r_vs_prev) r_inreg <= w_present;
    end
  end

  assign inreg = r_inreg;

endmodule
